// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signal bundle for the two-port data memory arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface dmem_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic                  req0_we;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic                  req1_valid;
   logic                  req1_ready;
   logic                  req1_we;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic                  rsp0_valid;
   logic [DATA_WIDTH-1:0] rsp0_rdata;
   logic                  rsp1_valid;
   logic [DATA_WIDTH-1:0] rsp1_rdata;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_we;
   logic                  mem_re;
   logic [DATA_WIDTH-1:0] mem_data_out;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
      output mem_addr, mem_data_in, mem_we, mem_re,
      input  mem_data_out
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
      input  mem_addr, mem_data_in, mem_we, mem_re,
      output mem_data_out
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the core LSU (0) and the loader/debug port (1).
// Grant/ready one cycle after valid is sampled, read data registered one cycle later; losers simply hold valid.
module dmem_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  rsp0_valid_q, rsp0_valid_d;
   logic                  rsp1_valid_q, rsp1_valid_d;
   logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
   logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;
   logic                  act0, act1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_rdata_q <= rsp0_rdata_d;
         rsp1_rdata_q <= rsp1_rdata_d;
      end
   end

   always_comb begin
      state_d          = IDLE;
      last_grant_d     = last_grant_q;
      bus.req0_ready   = 1'b0;
      bus.req1_ready   = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_re       = 1'b0;
      bus.mem_addr     = {ADDR_WIDTH{1'b0}};
      bus.mem_data_in  = {DATA_WIDTH{1'b0}};

      // Same arbitration from every state, so grants can run back to back.
      case ({bus.req1_valid, bus.req0_valid})
         2'b01:   state_d = GNT0;
         2'b10:   state_d = GNT1;
         2'b11:   state_d = last_grant_q ? GNT0 : GNT1;
         default: state_d = IDLE;
      endcase
      if (state_d == GNT0) begin
         last_grant_d = 1'b0;
      end else if (state_d == GNT1) begin
         last_grant_d = 1'b1;
      end

      // A grant whose requester has since dropped valid is a dead cycle.
      act0 = (state_q == GNT0) && bus.req0_valid;
      act1 = (state_q == GNT1) && bus.req1_valid;

      if (act0) begin
         bus.req0_ready  = 1'b1;
         bus.mem_addr    = bus.req0_addr;
         bus.mem_data_in = bus.req0_wdata;
         bus.mem_we      = bus.req0_we;
         bus.mem_re      = ~bus.req0_we;
      end else if (act1) begin
         bus.req1_ready  = 1'b1;
         bus.mem_addr    = bus.req1_addr;
         bus.mem_data_in = bus.req1_wdata;
         bus.mem_we      = bus.req1_we;
         bus.mem_re      = ~bus.req1_we;
      end

      rsp0_valid_d = act0 && !bus.req0_we;
      rsp1_valid_d = act1 && !bus.req1_we;
      rsp0_rdata_d = rsp0_valid_d ? bus.mem_data_out : rsp0_rdata_q;
      rsp1_rdata_d = rsp1_valid_d ? bus.mem_data_out : rsp1_rdata_q;
   end

   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_rdata = rsp0_rdata_q;
   assign bus.rsp1_rdata = rsp1_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single accesses, then tie, round-robin, reset-abort and dropped-valid sequences.
// Read responses are scoreboarded per requester with the cycle they are due in.
module tb_dmem_arbiter;
   localparam int DW = 32;
   localparam int AW = 4;

   typedef struct {
      bit            r;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   logic clk;
   logic rst;
   logic preload;
   logic [DW-1:0] mem [16];
   int   cyc;
   int   checks;
   int   failures;
   exp_t q0[$];
   exp_t q1[$];
   int   grant_log[$];
   vec_t vecs[12];

   dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Data memory: synchronous write, combinational read.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 32'hDEADBEEF : 32'h0;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_data_in;
      end
   end
   assign bus.mem_data_out = mem[bus.mem_addr];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
      end
   endtask

   function automatic logic get_ready(input bit r);
      return r ? bus.req1_ready : bus.req0_ready;
   endfunction

   task automatic drive(input bit r, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (!r) begin
         bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
      end else begin
         bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
      end
   endtask

   // Response monitor and grant recorder.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.req0_ready) grant_log.push_back(0);
         if (bus.req1_ready) grant_log.push_back(1);
         if (bus.rsp0_valid || bus.rsp1_valid)
            check("rsp_overlap", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
         if (bus.rsp0_valid) begin
            if (q0.size() == 0) check("rsp0_unexpected", bus.rsp0_valid, 1'b0);
            else begin
               e = q0.pop_front();
               check("rsp0_rdata", bus.rsp0_rdata, e.data);
               check("rsp0_cycle", cyc, e.due);
            end
         end
         if (bus.rsp1_valid) begin
            if (q1.size() == 0) check("rsp1_unexpected", bus.rsp1_valid, 1'b0);
            else begin
               e = q1.pop_front();
               check("rsp1_rdata", bus.rsp1_rdata, e.data);
               check("rsp1_cycle", cyc, e.due);
            end
         end
      end
   end

   task automatic check_all_idle(input string tag);
      check({tag, "_rdy0"}, bus.req0_ready, 1'b0);
      check({tag, "_rdy1"}, bus.req1_ready, 1'b0);
      check({tag, "_rsp0_vld"}, bus.rsp0_valid, 1'b0);
      check({tag, "_rsp1_vld"}, bus.rsp1_valid, 1'b0);
      check({tag, "_mem_we"}, bus.mem_we, 1'b0);
      check({tag, "_mem_re"}, bus.mem_re, 1'b0);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_q0_left"}, q0.size(), 0);
      check({tag, "_q1_left"}, q1.size(), 0);
   endtask

   task automatic single(input vec_t v, input int idx);
      int n;
      @(posedge clk); #1;
      drive(v.r, 1'b1, v.we, v.addr, v.wdata);
      @(negedge clk);
      check($sformatf("v%0d_rdy_first_cycle", idx), get_ready(v.r), 1'b0);
      @(negedge clk);
      n = 1;
      while (!get_ready(v.r) && n < 10) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("v%0d_rdy_latency", idx), n, 1);
      check($sformatf("v%0d_other_rdy", idx), get_ready(!v.r), 1'b0);
      check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
      check($sformatf("v%0d_mem_we", idx), bus.mem_we, v.we);
      check($sformatf("v%0d_mem_re", idx), bus.mem_re, !v.we);
      if (v.we) check($sformatf("v%0d_mem_data_in", idx), bus.mem_data_in, v.wdata);
      if (get_ready(v.r) && !v.we) begin
         if (v.r) q1.push_back('{data: v.exp_rdata, due: cyc + 1});
         else     q0.push_back('{data: v.exp_rdata, due: cyc + 1});
      end
      @(posedge clk); #1;
      drive(v.r, 1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      check_drained($sformatf("v%0d", idx));
   endtask

   // Both requesters read (0: addr 3, 1: addr 5); hold=1 keeps both valid across accesses.
   task automatic run_both(input int n_acc, input bit hold, input string tag);
      int  got, budget, first_c, last_c;
      bit  r0, r1;
      grant_log.delete();
      got = 0; budget = 0; first_c = -1; last_c = 0;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 4'd3, '0);
      drive(1'b1, 1'b1, 1'b0, 4'd5, '0);
      @(negedge clk);
      check({tag, "_rdy_first_cycle"}, {bus.req1_ready, bus.req0_ready}, 2'b00);
      while (got < n_acc && budget < 40) begin
         @(negedge clk);
         budget++;
         r0 = bus.req0_ready;
         r1 = bus.req1_ready;
         if (r0) begin q0.push_back('{data: 32'hDEADBEEF, due: cyc + 1}); got++; end
         if (r1) begin q1.push_back('{data: 32'h12345678, due: cyc + 1}); got++; end
         if (r0 || r1) begin
            if (first_c < 0) first_c = cyc;
            last_c = cyc;
         end
         @(posedge clk); #1;
         if (!hold && r0) drive(1'b0, 1'b0, 1'b0, '0, '0);
         if (!hold && r1) drive(1'b1, 1'b0, 1'b0, '0, '0);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      check({tag, "_count"}, got, n_acc);
      check({tag, "_span"}, last_c - first_c, n_acc - 1);
      repeat (3) @(negedge clk);
      check({tag, "_grants"}, grant_log.size(), n_acc);
      for (int i = 0; i < n_acc; i++)
         check($sformatf("%s_order%0d", tag, i), (i < grant_log.size()) ? grant_log[i] : -1, i % 2);
      check_drained(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 4'd3,  32'h0,        32'hDEADBEEF};
      vecs[1]  = '{1'b1, 1'b1, 4'd5,  32'h12345678, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 4'd5,  32'h0,        32'h12345678};
      vecs[3]  = '{1'b0, 1'b1, 4'd7,  32'hCAFEF00D, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 4'd7,  32'h0,        32'hCAFEF00D};
      vecs[5]  = '{1'b0, 1'b0, 4'd5,  32'h0,        32'h12345678};
      vecs[6]  = '{1'b0, 1'b1, 4'd15, 32'hFFFFFFFF, 32'h0};
      vecs[7]  = '{1'b0, 1'b0, 4'd15, 32'h0,        32'hFFFFFFFF};
      vecs[8]  = '{1'b1, 1'b1, 4'd0,  32'h00000001, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 4'd0,  32'h0,        32'h00000001};
      vecs[10] = '{1'b0, 1'b0, 4'd0,  32'h0,        32'h00000001};
      vecs[11] = '{1'b1, 1'b0, 4'd3,  32'h0,        32'hDEADBEEF};

      checks = 0;
      failures = 0;
      rst = 1'b1;
      preload = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      #1;
      check_all_idle("por");
      check("por_rsp0_rdata", bus.rsp0_rdata, 32'h0);
      check("por_rsp1_rdata", bus.rsp1_rdata, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      preload = 1'b0;
      rst = 1'b0;

      for (int i = 0; i < 12; i++) single(vecs[i], i);

      // Asynchronous reset mid-cycle clears registered read data.
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_all_idle("arst");
      check("arst_rsp0_rdata", bus.rsp0_rdata, 32'h0);
      check("arst_rsp1_rdata", bus.rsp1_rdata, 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      run_both(2, 1'b0, "tie");
      run_both(8, 1'b1, "rr");

      // Reset during a GNT1 write aborts it.
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b1, 4'd2, 32'hAAAA5555);
      @(posedge clk); #1;
      check("abort_granted_we", bus.mem_we, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_all_idle("abort");
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_mem2", mem[2], 32'h0);
      check_all_idle("abort_after");
      check("abort_rsp1_rdata", bus.rsp1_rdata, 32'h0);
      run_both(2, 1'b0, "tie_after_abort");

      // Valid withdrawn before its grant cycle: dead grant, no access.
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 4'd3, '0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check_all_idle("dropped");
      repeat (3) @(negedge clk);
      check_all_idle("dropped_after");
      check_drained("dropped");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
